alu_step_driver: RTL and testbench
==================================

// Module: alu_step_driver
// PURPOSE
//   Initiator side of the +/-5 ALU interface: drives the ALU's in1/in2/ALUop/iseq
//   inputs and consumes its res/sign outputs to walk an (x,y) coordinate N steps
//   along one axis and direction. It stops with an error on underflow (<0) or
//   overflow (>MAX_COORD). It sits between the top-level controller (start/done)
//   and one combinational ALU instance.
// PARAMETERS
//   SIZE       5   coordinate width; ALU in1/in2 width; alu_res is SIZE+1 bits
//   MAX_COORD  31  largest legal coordinate after an add step
//   CNT_W      3   width of the step-count request
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous reset, active-low
//   start     in   1        request; accepted only when ready=1
//   ready     out  1        1 in IDLE only
//   busy      out  1        1 in ISSUE/CHECK
//   x_in      in   SIZE     start x, loaded on accept
//   y_in      in   SIZE     start y, loaded on accept
//   dir       in   2        loaded on accept; [1] axis (0=x,1=y), [0] op (0=sub,1=add)
//   steps     in   CNT_W    number of +/-5 steps, loaded on accept
//   alu_in1   out  SIZE     = x_out register
//   alu_in2   out  SIZE     = y_out register
//   alu_op    out  1        = latched dir[0]
//   alu_iseq  out  1        = latched dir[1]
//   alu_res   in   SIZE+1   ALU result (combinational from alu_* outputs)
//   alu_sign  in   1        ALU sign = alu_res[SIZE]
//   x_out     out  SIZE     current/final x
//   y_out     out  SIZE     current/final y
//   done      out  1        one-cycle pulse, high in DONE state
//   err       out  1        1 = run aborted on a bound violation; sticky
// BEHAVIOUR
//   Reset (async on rst_n=0): state=IDLE, x_out=y_out=0, latched dir=0, remaining=0,
//     done=0, err=0, busy=0, ready=1. Reset mid-run aborts immediately; no done pulse.
//   States: IDLE, ISSUE, CHECK, DONE. All outputs are registered or decoded from state.
//   IDLE: on start=1 at edge k: x_out<=x_in, y_out<=y_in, latch dir, remaining<=steps,
//     err<=0. Next state is ISSUE if steps!=0, else DONE. start while not IDLE is ignored.
//   ISSUE: ALU sees the stable operands. At the edge, res_q<=alu_res and sgn_q<=alu_sign.
//     Next state is CHECK.
//   CHECK: a violation is (op=0 & sgn_q=1) or (op=1 & res_q>MAX_COORD), compared
//     unsigned on SIZE+1 bits.
//     On violation: err<=1, coordinates unchanged (last legal value), go to DONE.
//     Otherwise: selected coord <= res_q[SIZE-1:0], remaining<=remaining-1.
//       Go to DONE if remaining==1, else back to ISSUE.
//   DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
//   Latency: for N steps without error, done is high in cycle k+1+2N (N=0 -> k+1).
//     An error on step j gives done in cycle k+1+2j.
//   x_out, y_out and err hold their values from DONE until the next accepted start.
//   Only the selected axis is ever written; the other coordinate passes through unchanged.
// TESTING
//   1 x=10,y=3,dir=01,steps=3 -> x_out 15,20,25; done at k+7; err=0; y_out=3 throughout.
//   2 x=4,y=12,dir=10,steps=3 -> y_out 7,2; step 3 gives sign=1 -> err=1, y_out=2,
//     done at k+7.
//   3 x=25,dir=01,steps=2 -> x_out=30; step 2 res=35>31 -> err=1, x_out=30, done at k+5.
//   4 steps=0, x=9,y=9 -> done at k+1, x_out=y_out=9, err=0, ALU result never captured.
//   5 start pulsed in ISSUE/CHECK/DONE -> ignored, and the run is unchanged.
//     rst_n low during CHECK -> all outputs are reset values immediately and done
//     never pulses.
//   6 Back-to-back runs: an error run, then start in the first IDLE cycle with
//     x=0,dir=00,steps=1 -> err clears on accept; step 1 underflows -> err=1 again.
//     The errored run's x_out is cleanly replaced by x_in.

Source files
------------

// File: rtl/alu_step_driver.sv
// Walks an (x,y) coordinate N steps of +/-5 along one axis using an external combinational ALU.
// Latency: done pulses 1+2N cycles after an accepted start (earlier on a bound violation).
// Backpressure: start is only taken while ready=1; start in any other state is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start/ready/busy      request handshake; ready in IDLE, busy in ISSUE/CHECK
//   x_in, y_in, dir, steps  run parameters, latched on accept (dir[1]=axis, dir[0]=add)
//   alu_in1/in2/op/iseq   operands and controls driven to the ALU
//   alu_res, alu_sign     ALU result (SIZE+1 bits) and its MSB
//   x_out, y_out, err     current/final coordinates and sticky bound-violation flag
//   done                  one-cycle completion pulse
module alu_step_driver #(
    parameter int SIZE      = 5,
    parameter int MAX_COORD = 31,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    input  logic [SIZE-1:0]  x_in,
    input  logic [SIZE-1:0]  y_in,
    input  logic [1:0]       dir,
    input  logic [CNT_W-1:0] steps,
    output logic [SIZE-1:0]  alu_in1,
    output logic [SIZE-1:0]  alu_in2,
    output logic             alu_op,
    output logic             alu_iseq,
    input  logic [SIZE:0]    alu_res,
    input  logic             alu_sign,
    output logic [SIZE-1:0]  x_out,
    output logic [SIZE-1:0]  y_out,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

    localparam logic [SIZE:0] MAX_C = (SIZE+1)'(MAX_COORD);

    state_t           state_q, state_d;
    logic [SIZE-1:0]  x_q, x_d;
    logic [SIZE-1:0]  y_q, y_d;
    logic             op_q, op_d;
    logic             iseq_q, iseq_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [SIZE:0]    res_q, res_d;
    logic             sgn_q, sgn_d;
    logic             err_q, err_d;
    logic             violation;

    // Subtract underflow shows up as a set borrow bit; add overflow is an
    // unsigned compare on the full SIZE+1 result.
    assign violation = op_q ? (res_q > MAX_C) : sgn_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        iseq_d  = iseq_q;
        rem_d   = rem_q;
        res_d   = res_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    op_d    = dir[0];
                    iseq_d  = dir[1];
                    rem_d   = steps;
                    err_d   = 1'b0;
                    state_d = (steps != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                // Operands have been stable all cycle; capture the ALU answer.
                res_d   = alu_res;
                sgn_d   = alu_sign;
                state_d = CHECK;
            end
            CHECK: begin
                if (violation) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    if (iseq_q) y_d = res_q[SIZE-1:0];
                    else        x_d = res_q[SIZE-1:0];
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 1'b0;
            iseq_q  <= 1'b0;
            rem_q   <= '0;
            res_q   <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            iseq_q  <= iseq_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == ISSUE) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign alu_in1  = x_q;
    assign alu_in2  = y_q;
    assign alu_op   = op_q;
    assign alu_iseq = iseq_q;

endmodule

// File: tb/tb_alu_step_driver.sv
module tb_alu_step_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready, busy;
    logic [4:0] x_in, y_in;
    logic [1:0] dir;
    logic [2:0] steps;
    logic [4:0] alu_in1, alu_in2;
    logic       alu_op, alu_iseq;
    logic [5:0] alu_res;
    logic       alu_sign;
    logic [4:0] x_out, y_out;
    logic       done, err;

    int n_cmp = 0;
    int n_mis = 0;

    // Trace of coordinate changes seen while waiting for done, packed 5 bits per entry.
    logic [31:0] xtr, ytr;
    int          nx, ny;
    int          cyc;
    logic        seen_done;

    always #5 clk = ~clk;

    // Reference +/-5 ALU on the selected operand, SIZE+1 bits wide.
    logic [5:0] alu_a;
    assign alu_a    = {1'b0, (alu_iseq ? alu_in2 : alu_in1)};
    assign alu_res  = alu_op ? (alu_a + 6'd5) : (alu_a - 6'd5);
    assign alu_sign = alu_res[5];

    alu_step_driver #(.SIZE(5), .MAX_COORD(31), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .x_in     (x_in),
        .y_in     (y_in),
        .dir      (dir),
        .steps    (steps),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_op   (alu_op),
        .alu_iseq (alu_iseq),
        .alu_res  (alu_res),
        .alu_sign (alu_sign),
        .x_out    (x_out),
        .y_out    (y_out),
        .done     (done),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents a request in IDLE and returns #1 after the accepting edge (cycle k+1).
    task automatic launch(input logic [4:0] x, input logic [4:0] y,
                          input logic [1:0] d, input logic [2:0] s);
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        dir   = d;
        steps = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from k+1 until done is seen, tracing coordinate changes.
    task automatic wait_done(output int c);
        logic [4:0] px, py;
        c  = 1;
        xtr = 0; ytr = 0; nx = 0; ny = 0;
        px = x_out;
        py = y_out;
        while (done !== 1'b1 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
            if (x_out !== px) begin xtr = (xtr << 5) | 32'(x_out); nx++; px = x_out; end
            if (y_out !== py) begin ytr = (ytr << 5) | 32'(y_out); ny++; py = y_out; end
        end
    endtask

    // Advances past DONE and confirms the pulse was a single cycle.
    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        check_val({tag, "_done_1cyc"}, 32'(done), 0);
        check_val({tag, "_ready"}, 32'(ready), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        dir   = '0;
        steps = '0;
        #3;
        check_val("rst_ready", 32'(ready), 1);
        check_val("rst_busy",  32'(busy),  0);
        check_val("rst_done",  32'(done),  0);
        check_val("rst_err",   32'(err),   0);
        check_val("rst_xy",    {x_out, y_out}, 0);
        check_val("rst_ctl",   {alu_op, alu_iseq}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: x add, three clean steps.
        launch(5'd10, 5'd3, 2'b01, 3'd3);
        check_val("t1_busy",  32'(busy), 1);
        check_val("t1_ready", 32'(ready), 0);
        check_val("t1_in",    {alu_in1, alu_in2}, {5'd10, 5'd3});
        check_val("t1_ctl",   {alu_op, alu_iseq}, 2'b10);
        wait_done(cyc);
        check_val("t1_lat",   cyc, 7);
        check_val("t1_xtr",   xtr, (15 << 10) | (20 << 5) | 25);
        check_val("t1_nx",    nx, 3);
        check_val("t1_ny",    ny, 0);
        check_val("t1_y",     32'(y_out), 3);
        check_val("t1_err",   32'(err), 0);
        after_done("t1");
        check_val("t1_hold",  {err, x_out, y_out}, {1'b0, 5'd25, 5'd3});

        // 2: y subtract, underflow on step 3.
        launch(5'd4, 5'd12, 2'b10, 3'd3);
        wait_done(cyc);
        check_val("t2_lat",   cyc, 7);
        check_val("t2_ytr",   ytr, (7 << 5) | 2);
        check_val("t2_ny",    ny, 2);
        check_val("t2_nx",    nx, 0);
        check_val("t2_err",   32'(err), 1);
        check_val("t2_xy",    {x_out, y_out}, {5'd4, 5'd2});
        after_done("t2");
        check_val("t2_err_sticky", 32'(err), 1);

        // 3: x add, overflow on step 2.
        launch(5'd25, 5'd7, 2'b01, 3'd2);
        check_val("t3_err_clr", 32'(err), 0);
        wait_done(cyc);
        check_val("t3_lat",   cyc, 5);
        check_val("t3_xtr",   xtr, 30);
        check_val("t3_nx",    nx, 1);
        check_val("t3_err",   32'(err), 1);
        check_val("t3_xy",    {x_out, y_out}, {5'd30, 5'd7});
        after_done("t3");

        // 4: zero steps.
        launch(5'd9, 5'd9, 2'b01, 3'd0);
        check_val("t4_busy",  32'(busy), 0);
        wait_done(cyc);
        check_val("t4_lat",   cyc, 1);
        check_val("t4_xy",    {x_out, y_out}, {5'd9, 5'd9});
        check_val("t4_err",   32'(err), 0);
        after_done("t4");

        // 5a: start held through ISSUE/CHECK/DONE with different operands.
        launch(5'd10, 5'd3, 2'b01, 3'd3);
        x_in  = 5'd0;
        y_in  = 5'd0;
        dir   = 2'b10;
        steps = 3'd1;
        start = 1'b1;
        wait_done(cyc);
        check_val("t5_lat",   cyc, 7);
        check_val("t5_xtr",   xtr, (15 << 10) | (20 << 5) | 25);
        check_val("t5_xy",    {x_out, y_out}, {5'd25, 5'd3});
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("t5_idle",  {ready, busy, done}, 3'b100);
        check_val("t5_noacc", {x_out, y_out}, {5'd25, 5'd3});
        @(posedge clk);
        #1;
        check_val("t5_still_idle", 32'(ready), 1);

        // 5b: reset asserted during CHECK.
        launch(5'd10, 5'd3, 2'b01, 3'd3);
        @(posedge clk);
        #1;
        check_val("t5r_in_check", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_val("t5r_flags", {ready, busy, done, err}, 4'b1000);
        check_val("t5r_xy",    {x_out, y_out}, 0);
        check_val("t5r_ctl",   {alu_op, alu_iseq}, 0);
        seen_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check_val("t5r_no_done", 32'(seen_done), 0);
        check_val("t5r_ready",   32'(ready), 1);

        // 6: error run, then immediate restart in the first IDLE cycle.
        launch(5'd25, 5'd1, 2'b01, 3'd2);
        wait_done(cyc);
        check_val("t6a_err",  32'(err), 1);
        check_val("t6a_x",    32'(x_out), 30);
        @(posedge clk);
        #1;
        launch(5'd0, 5'd1, 2'b00, 3'd1);
        check_val("t6_err_clr", 32'(err), 0);
        check_val("t6_x_load",  32'(x_out), 0);
        wait_done(cyc);
        check_val("t6_lat",   cyc, 3);
        check_val("t6_err",   32'(err), 1);
        check_val("t6_xy",    {x_out, y_out}, {5'd0, 5'd1});
        after_done("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
